// File: rtl/outer_bits_pkg.sv
// outer_bits_pkg: shared walk-direction and FSM state types for the outer-bit iterator
package outer_bits_pkg;
    typedef enum logic {DIR_LSB = 1'b0, DIR_MSB = 1'b1} dir_e;
    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;
endpackage

// File: rtl/outer_bits_comb.sv
// outer_bits_comb: leftmost/rightmost set bit of a word as one-hot and index
module outer_bits_comb #(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] left_bit,
    output logic [WIDTH-1:0] right_bit,
    output logic [IDX_W-1:0] left_idx,
    output logic [IDX_W-1:0] right_idx,
    output logic             any
);
    always_comb begin
        left_idx = '0;
        right_idx = '0;
        for (int i = 0; i < WIDTH; i++) if (data[i]) left_idx = IDX_W'(i);
        for (int i = WIDTH - 1; i >= 0; i--) if (data[i]) right_idx = IDX_W'(i);
    end
    assign any = |data;
    // Two's-complement trick isolates the lowest set bit.
    assign right_bit = data & (~data + WIDTH'(1));
    assign left_bit = any ? (WIDTH'(1) << left_idx) : '0;
endmodule

// File: rtl/outer_bits_iter.sv
// outer_bits_iter: streams each set bit of an accepted word as one beat, LSB- or MSB-first
module outer_bits_iter
    import outer_bits_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int IDX_W = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_val_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             data_dir_i,
    output logic             data_ready_o,
    output logic             data_val_o,
    input  logic             data_ready_i,
    output logic [WIDTH-1:0] data_bit_o,
    output logic [IDX_W-1:0] data_idx_o,
    output logic [CNT_W-1:0] data_num_o,
    output logic             data_last_o,
    output logic             data_empty_o
);
    state_e           state;
    dir_e             dir;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] num;
    logic [WIDTH-1:0] left_bit, right_bit, sel_bit;
    logic [IDX_W-1:0] left_idx, right_idx, sel_idx;
    logic             any, single, accept, beat_done;

    outer_bits_comb #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_comb (
        .data      (rem),
        .left_bit  (left_bit),
        .right_bit (right_bit),
        .left_idx  (left_idx),
        .right_idx (right_idx),
        .any       (any)
    );

    assign sel_bit = (dir == DIR_MSB) ? left_bit : right_bit;
    assign sel_idx = (dir == DIR_MSB) ? left_idx : right_idx;
    // At most one bit left means this beat finishes the word (also covers the empty word).
    assign single = (rem & (rem - WIDTH'(1))) == '0;

    assign data_val_o   = state == ST_BUSY;
    assign data_bit_o   = data_val_o ? sel_bit : '0;
    assign data_idx_o   = data_val_o ? sel_idx : '0;
    assign data_num_o   = data_val_o ? num : '0;
    assign data_last_o  = data_val_o & single;
    assign data_empty_o = data_val_o & ~any;
    assign data_ready_o = (state == ST_IDLE) | (data_val_o & data_ready_i & data_last_o);

    assign accept    = data_val_i & data_ready_o;
    assign beat_done = data_val_o & data_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            dir <= DIR_LSB;
            rem <= '0;
            num <= '0;
        end else if (accept) begin
            state <= ST_BUSY;
            dir <= dir_e'(data_dir_i);
            rem <= data_i;
            num <= '0;
        end else if (beat_done) begin
            rem <= rem & ~sel_bit;
            num <= num + CNT_W'(1);
            if (data_last_o) state <= ST_IDLE;
        end
    end
endmodule

// File: tb/tb_outer_bits_iter.sv
// tb_outer_bits_iter: directed WIDTH=16 scenarios plus randomized WIDTH=4 sweep against a queue model
module tb_outer_bits_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        val_i = 1'b0, dir_i = 1'b0, rdy_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        sel = 1'b0;

    logic        a_ready, a_val, a_last, a_empty;
    logic [15:0] a_bit;
    logic [3:0]  a_idx;
    logic [4:0]  a_num;
    logic        b_ready, b_val, b_last, b_empty;
    logic [3:0]  b_bit;
    logic [1:0]  b_idx;
    logic [2:0]  b_num;

    logic        o_ready, o_val, o_last, o_empty;
    logic [15:0] o_bit;
    logic [3:0]  o_idx;
    logic [4:0]  o_num;

    int checks = 0;
    int errors = 0;
    int q[$];

    always #5 clk = ~clk;

    outer_bits_iter #(.WIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst), .data_val_i(val_i), .data_i(data_i), .data_dir_i(dir_i),
        .data_ready_o(a_ready), .data_val_o(a_val), .data_ready_i(rdy_i), .data_bit_o(a_bit),
        .data_idx_o(a_idx), .data_num_o(a_num), .data_last_o(a_last), .data_empty_o(a_empty)
    );

    outer_bits_iter #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .data_val_i(val_i), .data_i(data_i[3:0]), .data_dir_i(dir_i),
        .data_ready_o(b_ready), .data_val_o(b_val), .data_ready_i(rdy_i), .data_bit_o(b_bit),
        .data_idx_o(b_idx), .data_num_o(b_num), .data_last_o(b_last), .data_empty_o(b_empty)
    );

    assign o_ready = sel ? b_ready : a_ready;
    assign o_val   = sel ? b_val : a_val;
    assign o_last  = sel ? b_last : a_last;
    assign o_empty = sel ? b_empty : a_empty;
    assign o_bit   = sel ? {12'b0, b_bit} : a_bit;
    assign o_idx   = sel ? {2'b0, b_idx} : a_idx;
    assign o_num   = sel ? {2'b0, b_num} : a_num;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beat order: set-bit positions in walk order; -1 stands for the single empty-word beat.
    function automatic void build(input logic [15:0] word, input int w, input bit msb_first);
        q.delete();
        for (int k = 0; k < w; k++) begin
            int p = msb_first ? w - 1 - k : k;
            if (word[p]) q.push_back(p);
        end
        if (q.size() == 0) q.push_back(-1);
    endfunction

    task automatic beat_check(input string tag, input int idx, input int num, input bit last, input bit exp_ready);
        check({tag, ".val"}, 32'(o_val), 32'd1);
        check({tag, ".bit"}, 32'(o_bit), idx < 0 ? 32'd0 : 32'd1 << idx);
        check({tag, ".idx"}, 32'(o_idx), idx < 0 ? 32'd0 : 32'(idx));
        check({tag, ".num"}, 32'(o_num), 32'(num));
        check({tag, ".last"}, 32'(o_last), 32'(last));
        check({tag, ".empty"}, 32'(o_empty), 32'(idx < 0));
        check({tag, ".ready"}, 32'(o_ready), 32'(exp_ready));
    endtask

    task automatic idle_check(input string tag);
        check({tag, ".val"}, 32'(o_val), 32'd0);
        check({tag, ".bit"}, 32'(o_bit), 32'd0);
        check({tag, ".last"}, 32'(o_last), 32'd0);
        check({tag, ".ready"}, 32'(o_ready), 32'd1);
    endtask

    task automatic run(input bit s, input logic [15:0] word, input bit msb_first, input int stall_pct);
        int n = 0;
        int cycles = 0;
        build(word, s ? 4 : 16, msb_first);
        @(negedge clk);
        sel = s; val_i = 1'b1; data_i = word; dir_i = msb_first; rdy_i = 1'($urandom);
        #1 check("run.accept_ready", 32'(o_ready), 32'd1);
        while (q.size() > 0 && cycles < 200) begin
            @(negedge clk);
            val_i = 1'b0; data_i = 16'($urandom); dir_i = 1'($urandom);
            rdy_i = $urandom_range(0, 99) >= stall_pct;
            if (!rdy_i) val_i = 1'($urandom);
            #1 beat_check($sformatf("run[%0h,d%0d,n%0d]", word, msb_first, n), q[0], n, q.size() == 1, rdy_i && q.size() == 1);
            if (rdy_i) begin
                void'(q.pop_front());
                n++;
            end
            cycles++;
        end
        check("run.timeout", 32'(q.size()), 32'd0);
        @(negedge clk);
        val_i = 1'b0; rdy_i = 1'b1;
        #1 idle_check("run.idle");
    endtask

    int          t1_idx[4] = '{0, 5, 10, 15};
    logic [15:0] t1_bit[4] = '{16'h0001, 16'h0020, 16'h0400, 16'h8000};

    initial begin
        // reset state, both widths
        #1 idle_check("rst16");
        sel = 1'b1;
        #1 idle_check("rst4");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1 idle_check("post_rst");

        // 16'h8421 LSB-first with literal expectations
        @(negedge clk);
        val_i = 1'b1; data_i = 16'h8421; dir_i = 1'b0; rdy_i = 1'b1;
        #1 check("t1.ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            val_i = 1'b0;
            #1;
            check($sformatf("t1.idx%0d", k), 32'(o_idx), 32'(t1_idx[k]));
            check($sformatf("t1.bit%0d", k), 32'(o_bit), 32'(t1_bit[k]));
            check($sformatf("t1.num%0d", k), 32'(o_num), 32'(k));
            check($sformatf("t1.last%0d", k), 32'(o_last), 32'(k == 3));
            check($sformatf("t1.ready%0d", k), 32'(o_ready), 32'(k == 3));
        end
        @(negedge clk);
        #1 idle_check("t1.idle");

        // same word MSB-first, then empty word
        run(1'b0, 16'h8421, 1'b1, 0);
        run(1'b0, 16'h0000, 1'b0, 0);

        // stall on beat 0 with an ignored word offer
        @(negedge clk);
        val_i = 1'b1; data_i = 16'h0006; dir_i = 1'b0; rdy_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            val_i = k == 1; data_i = 16'hFFFF; rdy_i = 1'b0;
            #1 beat_check("t4.stall", 1, 0, 1'b0, 1'b0);
        end
        @(negedge clk);
        val_i = 1'b0; rdy_i = 1'b1;
        #1 beat_check("t4.b0", 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1 beat_check("t4.b1", 2, 1, 1'b1, 1'b1);
        @(negedge clk);
        #1 idle_check("t4.idle");

        // back-to-back words with no bubble
        @(negedge clk);
        val_i = 1'b1; data_i = 16'h0003; dir_i = 1'b0;
        #1 check("t5.ready", 32'(o_ready), 32'd1);
        @(negedge clk);
        data_i = 16'h8000;
        #1 beat_check("t5.b0", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1 beat_check("t5.b1", 1, 1, 1'b1, 1'b1);
        @(negedge clk);
        val_i = 1'b0;
        #1 beat_check("t5.w2", 15, 0, 1'b1, 1'b1);
        @(negedge clk);
        #1 idle_check("t5.idle");

        // asynchronous reset in the middle of an all-ones word
        @(negedge clk);
        val_i = 1'b1; data_i = 16'hFFFF; dir_i = 1'b0;
        @(negedge clk);
        val_i = 1'b0;
        #1 beat_check("t6.b0", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1 beat_check("t6.b1", 1, 1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1 idle_check("t6.rst");
        check("t6.rst.num", 32'(o_num), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 idle_check("t6.after");
        end

        // all-ones word to the end, and random WIDTH=16 words with backpressure
        run(1'b0, 16'hFFFF, 1'b1, 0);
        for (int k = 0; k < 12; k++) run(1'b0, 16'($urandom), 1'($urandom), 30);

        // exhaustive WIDTH=4 sweep, both directions, random backpressure
        for (int d = 0; d < 2; d++)
            for (int w = 0; w < 16; w++) run(1'b1, 16'(w), d[0], 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
